// File: rtl/serial_responder.sv
// ============================================================================
//  Module      : serial_responder
//  Description : 4021-style parallel-in/serial-out responder for the latch /
//                pulse shift protocol. latch and pulse are asynchronous to clk
//                and are synchronized and edge-detected before use.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_responder #(
    parameter int   BITS        = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL        = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            latch,
    input  logic            pulse,
    input  logic [BITS-1:0] data_in,
    output logic            data_out,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun
);

    localparam int              c_CNT_W = $clog2(BITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BITS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic [SYNC_STAGES-1:0] r_pulse_sync;
    logic                   r_latch_d;
    logic                   r_pulse_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch_sync <= '0;
            r_pulse_sync <= '0;
            r_latch_d    <= 1'b0;
            r_pulse_d    <= 1'b0;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latch};
            r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], pulse};
            r_latch_d    <= r_latch_sync[SYNC_STAGES-1];
            r_pulse_d    <= r_pulse_sync[SYNC_STAGES-1];
        end
    end

    logic w_latch_s;
    logic w_pulse_s;
    logic w_latch_rise;
    logic w_pulse_fall;

    assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
    assign w_pulse_s    = r_pulse_sync[SYNC_STAGES-1];
    assign w_latch_rise = w_latch_s & ~r_latch_d;
    assign w_pulse_fall = ~w_pulse_s & r_pulse_d;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [BITS-1:0]    r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_data_out;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_overrun;

    logic [1:0]         w_state_nxt;
    logic [BITS-1:0]    w_shift_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_overrun_nxt;
    logic               w_dout_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;

        // A latch rise aborts whatever frame is in flight, in any state.
        if (w_latch_rise) begin
            w_state_nxt   = c_ST_LOAD;
            w_shift_nxt   = data_in;
            w_cnt_nxt     = '0;
            w_busy_nxt    = 1'b0;
            w_overrun_nxt = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_latch_s) begin
                        w_state_nxt   = c_ST_LOAD;
                        w_shift_nxt   = data_in;
                        w_cnt_nxt     = '0;
                        w_busy_nxt    = 1'b0;
                        w_overrun_nxt = 1'b0;
                    end
                end
                c_ST_LOAD: begin
                    if (w_latch_s) begin
                        w_shift_nxt = data_in;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_ST_SHIFT;
                        w_busy_nxt  = 1'b1;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_latch_s) begin
                        w_state_nxt   = c_ST_LOAD;
                        w_shift_nxt   = data_in;
                        w_cnt_nxt     = '0;
                        w_busy_nxt    = 1'b0;
                        w_overrun_nxt = 1'b0;
                    end else if (w_pulse_fall) begin
                        if (r_cnt < c_CNT_LAST) begin
                            w_shift_nxt = {r_shift[BITS-2:0], FILL};
                            w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_done_nxt = 1'b1;
                            w_busy_nxt = 1'b0;
                            w_cnt_nxt  = c_CNT_FULL;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end

        // Output is registered from next-state values so it lands with the shift.
        if ((w_state_nxt == c_ST_IDLE) || (w_cnt_nxt >= c_CNT_FULL)) begin
            w_dout_nxt = FILL;
        end else begin
            w_dout_nxt = w_shift_nxt[BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_data_out   <= FILL;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_data_out   <= w_dout_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_done_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign data_out   = r_data_out;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_responder.sv
// ============================================================================
//  Module      : tb_serial_responder
//  Description : Self-checking bench for serial_responder; a master model
//                drives latch/pulse and checks the received bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_responder;

    localparam int   BITS        = 8;
    localparam int   SYNC_STAGES = 2;
    localparam logic FILL        = 1'b1;

    logic            clk = 1'b0;
    logic            reset;
    logic            latch;
    logic            pulse;
    logic [BITS-1:0] data_in;
    logic            data_out;
    logic            busy;
    logic            frame_done;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [BITS-1:0] rx;
    int              npulse;

    serial_responder #(
        .BITS        (BITS),
        .SYNC_STAGES (SYNC_STAGES),
        .FILL        (FILL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .latch      (latch),
        .pulse      (pulse),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One master clock pulse: high phase, sample on the falling edge, low phase.
    task automatic do_pulse(input int h, input logic [BITS-1:0] w);
        logic s;
        logic exp_bit;
        pulse = 1'b1;
        repeat (h) @(negedge clk);
        s = data_out;
        npulse++;
        exp_bit = (npulse <= BITS) ? w[BITS-npulse] : FILL;
        check($sformatf("bit%0d", npulse), {31'd0, s}, {31'd0, exp_bit});
        if (npulse <= BITS) rx = {rx[BITS-2:0], s};
        pulse = 1'b0;
        repeat (h) @(negedge clk);
    endtask

    // Latch pre then w into the responder, deliver n pulses, check the frame.
    task automatic run_frame(input logic [BITS-1:0] pre, input logic [BITS-1:0] w,
                             input logic [BITS-1:0] post, input int n, input int h,
                             input int glitch_at);
        int fd0;
        @(negedge clk);
        data_in = pre;
        latch   = 1'b1;
        repeat (6) @(negedge clk);
        data_in = w;
        repeat (10) @(negedge clk);
        check("busy_in_load", {31'd0, busy}, 32'd0);
        check("msb_at_latch_fall", {31'd0, data_out}, {31'd0, w[BITS-1]});
        latch  = 1'b0;
        npulse = 0;
        rx     = '0;
        fd0    = fd_cnt;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        data_in = post;
        check("busy_after_latch", {31'd0, busy}, 32'd1);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i == glitch_at) begin
                @(negedge clk);
                #1 pulse = 1'b1;
                #3 pulse = 1'b0;
                repeat (SYNC_STAGES + 4) @(negedge clk);
                check("glitch_no_shift", {31'd0, data_out}, {31'd0, w[BITS-1-i]});
            end
            if (i == BITS - 1) check("fd_not_early", fd_cnt - fd0, 32'd0);
            do_pulse(h, w);
        end
        if (n >= BITS) check("word", {24'd0, rx}, {24'd0, w});
        check("frame_done_count", fd_cnt - fd0, (n >= BITS) ? 32'd1 : 32'd0);
        check("busy_end", {31'd0, busy}, (n >= BITS) ? 32'd0 : 32'd1);
        check("overrun_end", {31'd0, overrun}, (n > BITS) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int fd0;
        logic [BITS-1:0] w;
        reset   = 1'b1;
        latch   = 1'b0;
        pulse   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", {31'd0, data_out}, {31'd0, FILL});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic frame with slow 40-clk pulse period.
        run_frame(8'hA5, 8'hA5, 8'hA5, BITS, 20, -1);
        // Last word loaded while latched wins; later data_in ignored.
        run_frame(8'h3C, 8'hC3, 8'h00, BITS, 8, -1);
        // Extra pulses: FILL on the line and overrun raised.
        run_frame(8'h5A, 8'h5A, 8'h5A, BITS + 2, 8, -1);
        // Abort after 3 pulses, then a fresh frame (also clears overrun).
        run_frame(8'hE7, 8'hE7, 8'hE7, 3, 8, -1);
        run_frame(8'h81, 8'h81, 8'h81, BITS, 8, -1);
        // Sub-clock glitch on pulse mid-frame must not shift.
        run_frame(8'h96, 8'h96, 8'h96, BITS, 8, 2);

        // Reset mid-frame.
        run_frame(8'hA5, 8'hA5, 8'hA5, 4, 8, -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_data_out", {31'd0, data_out}, {31'd0, FILL});
        check("midrst_busy", {31'd0, busy}, 32'd0);
        fd0 = fd_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse = 1'b1;
            repeat (8) @(negedge clk);
            pulse = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("idle_pulse_overrun", {31'd0, overrun}, 32'd0);
        check("idle_pulse_data_out", {31'd0, data_out}, {31'd0, FILL});
        check("idle_pulse_fd", fd_cnt - fd0, 32'd0);

        // Randomized frames.
        for (int k = 0; k < 4; k++) begin
            w = BITS'($urandom);
            run_frame(BITS'($urandom), w, BITS'($urandom),
                      BITS + int'($urandom_range(0, 2)),
                      int'($urandom_range(5, 10)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_responder.md
Name: serial_responder

Overview:
Parallel-in/serial-out responder for the latch/pulse shift protocol: the far end that our serial reader master talks to. It emulates a 4021/NES-pad style shift register inside the FPGA. It captures a BITS-wide word while latch is high, then presents it MSB-first on a single serial line, advancing one bit per falling edge of pulse. latch and pulse arrive from an external master and are asynchronous to clk, so both are synchronized and edge-detected internally.

Parameters:
BITS, 8, width of the parallel word and number of bits per frame (>=2)
SYNC_STAGES, 2, flip-flop stages on latch and pulse before edge detection (>=2)
FILL, 1'b1, serial level driven after all BITS bits have been consumed

Ports:
clk  input  1  system clock; all logic on posedge clk
reset  input  1  synchronous, active-high reset
latch  input  1  async from master; high = parallel load
pulse  input  1  async from master; each falling edge advances one bit
data_in  input  BITS  parallel word to transmit
data_out  output  1  serial bit presented to the master
busy  output  1  high from latch fall until frame end
frame_done  output  1  one-cycle strobe when bit BITS-1 (LSB) has been consumed
overrun  output  1  high when the master pulsed more than BITS times in the current frame

Behaviour:
- Sync: latch_s and pulse_s are the SYNC_STAGES-deep synchronized copies. Sync flops reset to 0. Edges are detected against one extra registered copy: rise = s & ~s_d, fall = ~s & s_d.
- Reset (sync, active-high): shift_reg=0, bit_cnt=0, state=IDLE, data_out=FILL, busy=0, frame_done=0, overrun=0.
- States: IDLE, LOAD, SHIFT.
- IDLE: data_out=FILL. On latch_s=1, go to LOAD.
- LOAD: every cycle, shift_reg<=data_in (continuous parallel load, as in a 4021) and bit_cnt<=0. data_out=shift_reg[BITS-1]. Pulse edges are ignored. overrun clears on entry to LOAD.
- On latch fall: freeze shift_reg (the last word loaded while latch_s was high), busy<=1, go to SHIFT.
- SHIFT, on each pulse fall:
  - If bit_cnt<BITS-1: shift_reg<={shift_reg[BITS-2:0],FILL} and bit_cnt<=bit_cnt+1.
  - If bit_cnt==BITS-1: frame_done=1 for that cycle, busy<=0, bit_cnt<=BITS, data_out<=FILL.
  - If bit_cnt==BITS: overrun<=1 and data_out stays FILL.
- data_out = shift_reg[BITS-1] while bit_cnt<BITS, else FILL. It is registered and changes SYNC_STAGES+1 clk after the pulse fall.
- Master timing contract: the master samples on the falling edge of latch and of each pulse, before our update lands. Sample 0 (latch fall) = MSB; pulse k fall (k=1..BITS) samples bit BITS-k before the shift. A master that keeps the last BITS samples therefore reconstructs data_in exactly. The master must hold each pulse low/high phase for >SYNC_STAGES+2 clk.
- Latch rise in any state: abort the current frame and go to LOAD. No frame_done is issued. busy<=0.
- Simultaneous latch_s=1 and pulse fall: latch wins and the pulse is ignored.
- Pulse edges in IDLE are ignored and do not set overrun.
- Reset mid-frame: all state returns to reset values on the next clk. A frame resumes only after a new latch.
- bit_cnt width is $clog2(BITS+1). It saturates at BITS and does not wrap.

Test Plan:
- BITS=8, data_in=8'hA5; latch high 10 clk, low; then 8 pulses, 40 clk period -> master model gets 8'hA5; frame_done once, after the 8th fall; busy low afterward; overrun=0.
- data_in changes 8'h3C->8'hC3 while latch high, then 8'h00 after latch fall -> frame delivers 8'hC3.
- 10 pulses after latch -> first 8 as in case 1; data_out=FILL=1 on extras; overrun=1 after the 9th fall; next latch clears overrun.
- Latch re-asserted after 3 pulses with data_in=8'h81 -> no frame_done; new frame delivers 8'h81.
- Reset asserted after 4 pulses -> data_out=1, busy=0, bit_cnt=0 next clk; pulses before the next latch are ignored with no overrun.
- Pulse glitch shorter than 1 clk -> no shift occurs; bit_cnt is unchanged.
